// File: rtl/uart_tx_frame.sv
// ============================================================================
// Module   : uart_tx_frame
// Purpose  : UART transmitter: start, 8 data bits LSB first, optional parity,
//            stop. Bit period set by Prescale. Optional macro
//            UART_TX_TWO_STOP_EN sends two stop bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_frame #(
    parameter int DATA_WIDTH     = 8,
    parameter int Prescale_width = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VALID,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [Prescale_width-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      busy,
    output logic                      DATA_ACK
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0]          LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]          BIT_ONE   = BIT_W'(1);
    localparam logic [Prescale_width-1:0] PRESC_ONE = Prescale_width'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                    state, state_n;
    logic [Prescale_width-1:0] cnt, cnt_n;
    logic [Prescale_width-1:0] last_cnt, last_cnt_n;
    logic [BIT_W-1:0]          bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0]     data, data_n;
    logic                      par_en, par_en_n;
    logic                      par_typ, par_typ_n;
    logic                      tx_n, busy_n, ack_n;
    logic                      load;
    logic                      cnt_done;
`ifdef UART_TX_TWO_STOP_EN
    logic                      stop2, stop2_n;
`endif

    assign cnt_done = (cnt == last_cnt);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            cnt      <= '0;
            last_cnt <= '0;
            bit_cnt  <= '0;
            data     <= '0;
            par_en   <= 1'b0;
            par_typ  <= 1'b0;
            TX_OUT   <= 1'b1;
            busy     <= 1'b0;
            DATA_ACK <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop2    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            last_cnt <= last_cnt_n;
            bit_cnt  <= bit_cnt_n;
            data     <= data_n;
            par_en   <= par_en_n;
            par_typ  <= par_typ_n;
            TX_OUT   <= tx_n;
            busy     <= busy_n;
            DATA_ACK <= ack_n;
`ifdef UART_TX_TWO_STOP_EN
            stop2    <= stop2_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        last_cnt_n = last_cnt;
        bit_cnt_n  = bit_cnt;
        data_n     = data;
        par_en_n   = par_en;
        par_typ_n  = par_typ;
        ack_n      = 1'b0;
        load       = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        stop2_n    = stop2;
`endif

        if (state != IDLE) begin
            cnt_n = cnt_done ? '0 : cnt + PRESC_ONE;
        end

        unique case (state)
            IDLE: begin
                if (DATA_VALID) load = 1'b1;
            end
            START: begin
                if (cnt_done) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (cnt_done) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_n = par_en ? PARITY : STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_ONE;
                    end
                end
            end
            PARITY: begin
                if (cnt_done) state_n = STOP;
            end
            STOP: begin
                if (cnt_done) begin
`ifdef UART_TX_TWO_STOP_EN
                    if (!stop2) begin
                        stop2_n = 1'b1;
                    end else begin
                        stop2_n = 1'b0;
                        if (DATA_VALID) load = 1'b1;
                        else            state_n = IDLE;
                    end
`else
                    if (DATA_VALID) load = 1'b1;
                    else            state_n = IDLE;
`endif
                end
            end
            default: state_n = IDLE;
        endcase

        // Accepting a word snapshots the whole frame configuration; Prescale=0 acts as 1.
        if (load) begin
            state_n    = START;
            cnt_n      = '0;
            bit_cnt_n  = '0;
            data_n     = P_DATA;
            par_en_n   = PAR_EN;
            par_typ_n  = PAR_TYP;
            last_cnt_n = (Prescale == '0) ? '0 : Prescale - PRESC_ONE;
            ack_n      = 1'b1;
        end
    end

    // Outputs are derived from the next state so they appear registered with it.
    always_comb begin
        busy_n = (state_n != IDLE);
        tx_n   = 1'b1;
        unique case (state_n)
            IDLE:    tx_n = 1'b1;
            START:   tx_n = 1'b0;
            DATA:    tx_n = data_n[bit_cnt_n];
            PARITY:  tx_n = par_typ_n ? ~^data_n : ^data_n;
            STOP:    tx_n = 1'b1;
            default: tx_n = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Serial UART transmitter that sends the response path of the UART command link: ALU results and register read data, one byte at a time, back to the host.
- Sits between the TX-side async FIFO read port and the TX_OUT pin.
- Runs in the UART clock domain.
- Frame format: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Each bit period is programmable in clock cycles, so the host-side deserializer sees 1 bit per 32 UART_CLK cycles (115.2 kbaud from 3.6864 MHz).

Parameters:
DATA_WIDTH, 8, width of the parallel data word.
Prescale_width, 6, width of the Prescale input (cycles per bit).

Ports:
CLK  input  1  UART clock; all logic on rising edge.
RST  input  1  asynchronous, active-low reset.
P_DATA  input  DATA_WIDTH  byte to send; valid while DATA_VALID=1.
DATA_VALID  input  1  word available (FIFO not-empty).
PAR_EN  input  1  1 = insert parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
Prescale  input  Prescale_width  clock cycles per bit.
TX_OUT  output  1  serial line, idle high.
busy  output  1  high for the whole frame.
DATA_ACK  output  1  one-cycle pulse when a word is consumed (drives FIFO read-increment).

Behaviour:
- Reset (async, RST=0):
  - TX_OUT=1, busy=0, DATA_ACK=0.
  - State IDLE, bit and cycle counters 0, data latch 0.
  - Reset asserted mid-frame aborts the frame immediately; no partial bits after release.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - TX_OUT=1, busy=0.
  - On an edge with DATA_VALID=1: latch P_DATA, PAR_EN, PAR_TYP, Prescale; go to START.
  - In the following cycle: TX_OUT=0, busy=1, DATA_ACK=1 for exactly that cycle.
- Bit duration:
  - Every state except IDLE lasts exactly Pl cycles, where Pl is the latched Prescale.
  - Pl=0 is treated as 1.
  - A cycle counter runs 0..Pl-1; the state advances when count = Pl-1.
- START: TX_OUT=0, then DATA.
- DATA:
  - TX_OUT = data[bit_cnt], bit_cnt 0..7, LSB first.
  - After bit 7: go to PARITY if PAR_EN latched=1, else STOP.
- PARITY: TX_OUT = ^data when even, ~^data when odd, computed on the latched byte.
- STOP (last cycle), TX_OUT=1 throughout:
  - DATA_VALID=1 on the last-cycle edge: back-to-back frame. Latch the new word and config, go to START (next cycle TX_OUT=0, DATA_ACK=1, busy stays 1, no idle bit).
  - Otherwise go to IDLE; busy=0 next cycle.
- Frame length: (10 + PAR_EN) × Pl cycles of busy=1, e.g. 352 cycles at Pl=32 with parity.
- Changes on P_DATA, PAR_EN, PAR_TYP, Prescale during a frame have no effect on that frame.
- DATA_VALID is only sampled in IDLE and on the STOP last cycle.
- DATA_ACK never asserts twice per frame and never asserts while RST=0.

Optional Feature:
UART_TX_TWO_STOP_EN
- Defined: STOP lasts 2×Pl cycles (two stop bits). Frame = (11 + PAR_EN) × Pl cycles. The back-to-back check moves to the last cycle of the second stop bit.
- Undefined: one stop bit, as above.

Test Plan:
1. Reset then release, DATA_VALID=0 for 1000 cycles -> TX_OUT=1, busy=0, DATA_ACK never pulses.
2. Prescale=32, PAR_EN=1, PAR_TYP=0, P_DATA=8'hA5:
   - line = 0, 1,0,1,0,0,1,0,1, parity 0, stop 1; each bit 32 cycles.
   - busy high 352 cycles; single DATA_ACK in the first START cycle.
3. Prescale=32, PAR_EN=1, P_DATA=8'h01:
   - PAR_TYP=0 -> parity bit 1.
   - PAR_TYP=1 -> parity bit 0.
4. PAR_EN=0, P_DATA=8'hFF, Prescale=32 -> 10-bit frame, busy 320 cycles, no parity slot.
5. Back-to-back: DATA_VALID held high with words 8'h28 then 8'h1C (PAR_EN=1, Prescale=32):
   - two frames with no idle bit between them.
   - DATA_ACK pulses exactly 352 cycles apart.
   - busy never drops between frames.
6. Reset asserted during data bit 3 of 8'hBD -> TX_OUT=1 and busy=0 asynchronously. After release with DATA_VALID=0, line stays idle. Re-sending 8'hBD gives a clean full frame.
